// File: rtl/cacheline_pkg.sv
// Shared constants, FSM state encoding and address alignment helper for the cacheline adapter.
package cacheline_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
    endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Arbiter-side line port plus memory-side burst port of the cacheline adapter.
interface cacheline_adapter_if;
    import cacheline_pkg::*;

    logic [LINE_WIDTH-1:0]  line_i;
    logic [LINE_WIDTH-1:0]  line_o;
    logic [ADDR_WIDTH-1:0]  address_i;
    logic                   read_i;
    logic                   write_i;
    logic                   resp_o;
    logic [BURST_WIDTH-1:0] burst_i;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [ADDR_WIDTH-1:0]  address_o;
    logic                   read_o;
    logic                   write_o;
    logic                   resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );

endinterface

// File: rtl/cacheline_adapter.sv
// Splits one 256-bit line request into a 4-beat 64-bit burst; resp_o pulses one cycle after the 4th beat.
// Memory paces the burst with resp_i (stalls hold state); requests are sampled only in IDLE.
module cacheline_adapter
    import cacheline_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    cacheline_adapter_if.slave  bus
);

    state_t                                   state, state_nxt;
    logic [1:0]                               cnt;
    logic [BEATS-1:0][BURST_WIDTH-1:0]        buffer;
    logic [ADDR_WIDTH-1:0]                    addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            buffer <= '0;
            addr   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.write_i) begin
                        buffer <= bus.line_i;
                        addr   <= line_align(bus.address_i);
                        cnt    <= 2'd0;
                    end else if (bus.read_i) begin
                        addr   <= line_align(bus.address_i);
                        cnt    <= 2'd0;
                    end
                end
                READ: begin
                    if (bus.resp_i) begin
                        buffer[cnt] <= bus.burst_i;
                        cnt         <= cnt + 2'd1;
                    end
                end
                WRITE: begin
                    if (bus.resp_i) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter wraps to 0 on the final beat, which is also the move into DONE.
    always_comb begin
        state_nxt     = state;
        bus.read_o    = 1'b0;
        bus.write_o   = 1'b0;
        bus.resp_o    = 1'b0;
        bus.address_o = '0;
        bus.burst_o   = '0;
        case (state)
            IDLE: begin
                if (bus.write_i) begin
                    state_nxt = WRITE;
                end else if (bus.read_i) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                bus.read_o    = 1'b1;
                bus.address_o = addr;
                if (bus.resp_i && cnt == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            WRITE: begin
                bus.write_o   = 1'b1;
                bus.address_o = addr;
                bus.burst_o   = buffer[cnt];
                if (bus.resp_i && cnt == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.resp_o = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.line_o = buffer;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed-vector bench for cacheline_adapter: reads, stalled write, request priority, reset, stray resp_i.
module tb_cacheline_adapter;
    import cacheline_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_adapter_if bus();

    cacheline_adapter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [BURST_WIDTH-1:0] beats [4];
    logic [LINE_WIDTH-1:0]  exp_line;

    task automatic chk(input string tag, input logic [LINE_WIDTH-1:0] obs,
                       input logic [LINE_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_read_o",    bus.read_o,    0);
        chk("rst_write_o",   bus.write_o,   0);
        chk("rst_resp_o",    bus.resp_o,    0);
        chk("rst_address_o", bus.address_o, 0);
        chk("rst_burst_o",   bus.burst_o,   0);
        chk("rst_line_o",    bus.line_o,    0);

        // Read with four consecutive beats
        beats[0] = {16{4'h1}};
        beats[1] = {16{4'h2}};
        beats[2] = {16{4'h3}};
        beats[3] = {16{4'h4}};
        bus.read_i    = 1'b1;
        bus.address_i = 32'h0000_1234;
        tick();
        bus.read_i    = 1'b0;
        chk("rd1_address_o", bus.address_o, 32'h0000_1220);
        chk("rd1_write_o",   bus.write_o,   0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rd1_read_o_b%0d", i), bus.read_o, 1);
            chk($sformatf("rd1_resp_o_b%0d", i), bus.resp_o, 0);
            bus.resp_i  = 1'b1;
            bus.burst_i = beats[i];
            tick();
        end
        bus.resp_i = 1'b0;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        chk("rd1_resp_o_done", bus.resp_o, 1);
        chk("rd1_read_o_done", bus.read_o, 0);
        chk("rd1_line_o",      bus.line_o, exp_line);
        tick();
        chk("rd1_resp_o_idle", bus.resp_o, 0);
        chk("rd1_line_hold",   bus.line_o, exp_line);

        // Write with two stall cycles before every beat; line_i changes after acceptance
        beats[0] = {16{4'hA}};
        beats[1] = {16{4'hB}};
        beats[2] = {16{4'hC}};
        beats[3] = {16{4'hD}};
        bus.line_i    = {beats[3], beats[2], beats[1], beats[0]};
        bus.address_i = 32'h8000_005F;
        bus.write_i   = 1'b1;
        tick();
        bus.write_i   = 1'b0;
        bus.line_i    = '1;
        chk("wr_address_o", bus.address_o, 32'h8000_0040);
        chk("wr_read_o",    bus.read_o,    0);
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 2; s++) begin
                bus.resp_i = 1'b0;
                chk($sformatf("wr_write_o_b%0d_s%0d", i, s), bus.write_o, 1);
                chk($sformatf("wr_burst_o_b%0d_s%0d", i, s), bus.burst_o, beats[i]);
                chk($sformatf("wr_resp_o_b%0d_s%0d", i, s),  bus.resp_o,  0);
                tick();
            end
            chk($sformatf("wr_burst_o_b%0d", i), bus.burst_o, beats[i]);
            bus.resp_i = 1'b1;
            tick();
        end
        bus.resp_i = 1'b0;
        chk("wr_resp_o_done",  bus.resp_o,  1);
        chk("wr_write_o_done", bus.write_o, 0);
        tick();
        chk("wr_resp_o_idle",  bus.resp_o,  0);
        chk("wr_write_o_idle", bus.write_o, 0);

        // Simultaneous read_i and write_i: write wins
        bus.line_i    = {64'h4, 64'h3, 64'h2, 64'h1};
        bus.address_i = 32'h0000_0040;
        bus.read_i    = 1'b1;
        bus.write_i   = 1'b1;
        tick();
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        chk("both_write_o", bus.write_o, 1);
        chk("both_read_o",  bus.read_o,  0);
        chk("both_burst_o", bus.burst_o, 64'h1);
        bus.resp_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.resp_i = 1'b0;
        chk("both_resp_o", bus.resp_o, 1);
        tick();

        // Reset after beat 2 of a read, then a clean read from counter 0
        bus.read_i    = 1'b1;
        bus.address_i = 32'h0000_0100;
        tick();
        bus.read_i    = 1'b0;
        bus.resp_i    = 1'b1;
        bus.burst_i   = {16{4'h5}};
        tick();
        bus.burst_i   = {16{4'h6}};
        tick();
        bus.resp_i    = 1'b0;
        rst           = 1'b1;
        tick();
        rst           = 1'b0;
        chk("mrst_read_o",    bus.read_o,    0);
        chk("mrst_resp_o",    bus.resp_o,    0);
        chk("mrst_line_o",    bus.line_o,    0);
        chk("mrst_address_o", bus.address_o, 0);
        beats[0] = {16{4'h7}};
        beats[1] = {16{4'h8}};
        beats[2] = {16{4'h9}};
        beats[3] = {16{4'hE}};
        bus.read_i    = 1'b1;
        bus.address_i = 32'h2000_003F;
        tick();
        bus.read_i    = 1'b0;
        chk("rd2_address_o", bus.address_o, 32'h2000_0020);
        for (int i = 0; i < 4; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = beats[i];
            tick();
        end
        bus.resp_i = 1'b0;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        chk("rd2_resp_o", bus.resp_o, 1);
        chk("rd2_line_o", bus.line_o, exp_line);
        tick();

        // Stray resp_i while IDLE
        bus.resp_i  = 1'b1;
        bus.burst_i = {16{4'hF}};
        tick();
        chk("stray_resp_o",  bus.resp_o,  0);
        chk("stray_read_o",  bus.read_o,  0);
        chk("stray_write_o", bus.write_o, 0);
        tick();
        bus.resp_i = 1'b0;
        chk("stray_resp_o2", bus.resp_o, 0);
        chk("stray_line_o",  bus.line_o, exp_line);

        // Request dropped after beat 1; address_i changes have no effect
        beats[0] = 64'h0123_4567_89AB_CDEF;
        beats[1] = 64'hFEDC_BA98_7654_3210;
        beats[2] = 64'hDEAD_BEEF_0000_0001;
        beats[3] = 64'hCAFE_F00D_0000_0002;
        bus.read_i    = 1'b1;
        bus.address_i = 32'h0000_0080;
        tick();
        bus.resp_i    = 1'b1;
        bus.burst_i   = beats[0];
        tick();
        bus.read_i    = 1'b0;
        bus.address_i = 32'hFFFF_FFFF;
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("drop_read_o_b%0d", i),    bus.read_o,    1);
            chk($sformatf("drop_address_o_b%0d", i), bus.address_o, 32'h0000_0080);
            bus.burst_i = beats[i];
            tick();
        end
        bus.resp_i = 1'b0;
        chk("drop_resp_o", bus.resp_o, 1);
        chk("drop_line_o", bus.line_o, {beats[3], beats[2], beats[1], beats[0]});
        tick();
        chk("drop_resp_o_once", bus.resp_o, 0);
        chk("drop_read_o_idle", bus.read_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
